// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED pattern sequencer: switch mode values and
// sweep direction.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_SCAN   = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_BAR    = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_sequencer_if.sv
// Step controls coming in from the switches and timing block, and the LED
// drive going out.
interface led_sequencer_if #(
  parameter int LED_WIDTH = 8
) ();
  logic                 enable;
  logic                 run;
  logic [1:0]           mode;
  logic [LED_WIDTH-1:0] led;
  logic                 wrap;

  modport master (output enable, run, mode, input led, wrap);
  modport slave  (input enable, run, mode, output led, wrap);
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous switch bit.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // NOTE: non-blocking assignments keep meta and q as two separate flops;
  // blocking ones here would collapse the chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: scan, rotate, bar and blink patterns advanced one
// step per enable strobe while the run switch is on.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int LED_WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  led_sequencer_if.slave bus
);
  localparam int PW = $clog2(LED_WIDTH);
  localparam int CW = $clog2(LED_WIDTH + 1);

  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [PW-1:0] POS_LAST = PW'(LED_WIDTH - 1);
  localparam logic [PW-1:0] POS_TURN = PW'(LED_WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TURN = CW'(LED_WIDTH - 1);

  localparam logic [LED_WIDTH-1:0] LED_ONE = {{(LED_WIDTH-1){1'b0}}, 1'b1};
  localparam int BW = 2 * ((LED_WIDTH + 1) / 2);
  localparam logic [BW-1:0]        BLINK_FULL = {((LED_WIDTH + 1) / 2){2'b01}};
  localparam logic [LED_WIDTH-1:0] BLINK_INIT = BLINK_FULL[LED_WIDTH-1:0];

  logic                 run_s;
  logic [1:0]           mode_raw;
  mode_e                mode_s;
  mode_e                mode_l;
  dir_e                 dir;
  logic [PW-1:0]        pos;
  logic [CW-1:0]        cnt;
  logic [LED_WIDTH-1:0] led;
  logic                 wrap;
  logic                 step;

  sync2 u_sync_run   (.clk(clk), .rst_n(rst_n), .d(bus.run),     .q(run_s));
  sync2 u_sync_mode0 (.clk(clk), .rst_n(rst_n), .d(bus.mode[0]), .q(mode_raw[0]));
  sync2 u_sync_mode1 (.clk(clk), .rst_n(rst_n), .d(bus.mode[1]), .q(mode_raw[1]));

  assign mode_s = mode_e'(mode_raw);
  assign step   = bus.enable & run_s;

  // The latched mode is the FSM state; led is shifted rather than decoded
  // from pos/cnt, which still track the pattern position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led    <= LED_ONE;
      wrap   <= 1'b0;
      mode_l <= MODE_SCAN;
      pos    <= '0;
      cnt    <= '0;
      dir    <= DIR_UP;
    end else begin
      wrap <= 1'b0;
      if (step) begin
        if (mode_s != mode_l) begin
          mode_l <= mode_s;
          pos    <= '0;
          cnt    <= '0;
          dir    <= DIR_UP;
          case (mode_s)
            MODE_BAR:   led <= '0;
            MODE_BLINK: led <= BLINK_INIT;
            default:    led <= LED_ONE;
          endcase
        end else begin
          case (mode_l)
            MODE_SCAN: begin
              if (dir == DIR_UP) begin
                pos <= pos + POS_ONE;
                led <= led << 1;
                if (pos == POS_TURN) dir <= DIR_DOWN;
              end else begin
                pos <= pos - POS_ONE;
                led <= led >> 1;
                if (pos == POS_ONE) begin
                  dir  <= DIR_UP;
                  wrap <= 1'b1;
                end
              end
            end
            MODE_ROTATE: begin
              led <= {led[LED_WIDTH-2:0], led[LED_WIDTH-1]};
              if (pos == POS_LAST) begin
                pos  <= '0;
                wrap <= 1'b1;
              end else begin
                pos <= pos + POS_ONE;
              end
            end
            MODE_BAR: begin
              if (dir == DIR_UP) begin
                cnt <= cnt + CNT_ONE;
                led <= {led[LED_WIDTH-2:0], 1'b1};
                if (cnt == CNT_TURN) dir <= DIR_DOWN;
              end else begin
                cnt <= cnt - CNT_ONE;
                led <= led >> 1;
                if (cnt == CNT_ONE) begin
                  dir  <= DIR_UP;
                  wrap <= 1'b1;
                end
              end
            end
            MODE_BLINK: begin
              led <= ~led;
              if (led != BLINK_INIT) wrap <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bus.led  = led;
  assign bus.wrap = wrap;
endmodule

// File: tb/tb_led_sequencer.sv
// Randomized and directed checks of led_sequencer against a period/index
// model of each pattern.
module tb_led_sequencer;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  led_sequencer_if #(.LED_WIDTH(W)) bus ();

  led_sequencer #(.LED_WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: latched mode plus index k within that mode's period.
  int           cur_run  = 0;
  int           cur_mode = 0;
  int           m_mode   = 0;
  int           m_k      = 0;
  logic [W-1:0] exp_led  = 1;
  logic         exp_wrap = 1'b0;

  function automatic int period(input int m);
    case (m)
      0:       return 2 * W - 2;
      1:       return W;
      2:       return 2 * W;
      default: return 2;
    endcase
  endfunction

  function automatic logic [W-1:0] pattern(input int m, input int k);
    logic [W-1:0] one;
    logic [W-1:0] alt;
    int           p;
    one = 1;
    for (int i = 0; i < W; i++) alt[i] = (i % 2 == 0);
    case (m)
      0: begin
        p = (k < W) ? k : 2 * W - 2 - k;
        return one << p;
      end
      1: return one << k;
      2: begin
        p = (k <= W) ? k : 2 * W - k;
        return (one << p) - 1;
      end
      default: return (k % 2 == 0) ? alt : ~alt;
    endcase
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_k      = 0;
    exp_led  = 1;
    exp_wrap = 1'b0;
  endtask

  task automatic drive_cycle(input logic en);
    @(negedge clk);
    bus.enable = en;
    @(posedge clk);
    if (en && cur_run != 0) begin
      if (cur_mode != m_mode) begin
        m_mode   = cur_mode;
        m_k      = 0;
        exp_wrap = 1'b0;
      end else begin
        m_k      = (m_k + 1) % period(m_mode);
        exp_wrap = (m_k == 0);
      end
      exp_led = pattern(m_mode, m_k);
    end else begin
      exp_wrap = 1'b0;
    end
    #1;
  endtask

  // Change switches, then let them through the synchronizers with no steps.
  task automatic set_inputs(input int run, input int mode);
    @(negedge clk);
    bus.run    = run[0];
    bus.mode   = mode[1:0];
    bus.enable = 1'b0;
    cur_run    = run;
    cur_mode   = mode;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0);
  endtask

  task automatic test_reset();
    rst_n      = 1'b1;
    bus.enable = 1'b0;
    bus.run    = 1'b0;
    bus.mode   = 2'b00;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.led !== 8'h01) begin
      errors++;
      $display("FAIL reset_led: got %h want 01", bus.led);
    end
    checks++;
    if (bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap: got %b want 0", bus.wrap);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_inputs(1, 0);
    checks++;
    if (bus.led !== 8'h01 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL release_no_step: got led=%h wrap=%b want 01/0", bus.led, bus.wrap);
    end
  endtask

  task automatic run_steps(input string name, input int n);
    for (int i = 1; i <= n; i++) begin
      drive_cycle(1'b1);
      checks++;
      if (bus.led !== exp_led) begin
        errors++;
        $display("FAIL %s_led step %0d: got %h want %h", name, i, bus.led, exp_led);
      end
      checks++;
      if (bus.wrap !== exp_wrap) begin
        errors++;
        $display("FAIL %s_wrap step %0d: got %b want %b", name, i, bus.wrap, exp_wrap);
      end
    end
  endtask

  task automatic test_scan();
    set_inputs(1, 0);
    run_steps("scan", 20);
  endtask

  task automatic test_rotate();
    set_inputs(1, 1);
    run_steps("rotate", 9);
  endtask

  task automatic test_bar();
    set_inputs(1, 2);
    run_steps("bar", 17);
  endtask

  task automatic test_blink();
    set_inputs(1, 3);
    run_steps("blink", 4);
  endtask

  task automatic test_freeze();
    int guard;
    set_inputs(1, 0);
    guard = 0;
    while (exp_led !== 8'h10 && guard < 40) begin
      drive_cycle(1'b1);
      guard++;
    end
    checks++;
    if (bus.led !== 8'h10) begin
      errors++;
      $display("FAIL freeze_reach: got %h want 10 after %0d steps", bus.led, guard);
    end
    set_inputs(0, 0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1);
      checks++;
      if (bus.led !== 8'h10 || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL freeze_hold %0d: got led=%h wrap=%b want 10/0", i, bus.led, bus.wrap);
      end
    end
    set_inputs(1, 0);
    run_steps("freeze_resume", 3);
  endtask

  task automatic test_reset_mid();
    int guard;
    set_inputs(1, 2);
    guard = 0;
    while (exp_led !== 8'h3f && guard < 40) begin
      drive_cycle(1'b1);
      guard++;
    end
    checks++;
    if (bus.led !== 8'h3f) begin
      errors++;
      $display("FAIL midreset_reach: got %h want 3f after %0d steps", bus.led, guard);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.led !== 8'h01 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got led=%h wrap=%b want 01/0", bus.led, bus.wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_inputs(1, 2);
    run_steps("midreset_reinit", 2);
    checks++;
    if (m_k != 1) begin
      errors++;
      $display("FAIL midreset_model: got k=%0d want 1", m_k);
    end
  endtask

  task automatic test_random();
    int run;
    int mode;
    int len;
    for (int seg = 0; seg < 25; seg++) begin
      run  = ($urandom_range(0, 4) != 0) ? 1 : 0;
      mode = $urandom_range(0, 3);
      len  = $urandom_range(10, 40);
      set_inputs(run, mode);
      for (int i = 0; i < len; i++) begin
        drive_cycle(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
        checks++;
        if (bus.led !== exp_led || bus.wrap !== exp_wrap) begin
          errors++;
          $display("FAIL random seg %0d cyc %0d mode %0d: got led=%h wrap=%b want %h/%b",
                   seg, i, mode, bus.led, bus.wrap, exp_led, exp_wrap);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_rotate();
    test_bar();
    test_blink();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
